// File: rtl/dds_wavegen_if.sv
// ---------------------------------------------------------------------------
// dds_wavegen_if
//   Control/configuration and sample-stream bundle for the DDS waveform
//   generator.
//
//   Control (master -> slave):
//     en          1 = generate, 0 = stop at the next phase wrap
//     cfg_load    one-cycle strobe capturing wave_sel/ftw/phase_ofs/amp
//     wave_sel    0 sine, 1 square, 2 triangle, 3 sawtooth
//     ftw         frequency tuning word (accumulator step)
//     phase_ofs   phase offset added to the table address
//     amp         amplitude gain, 256 = unity, larger values clamp to 256
//   Status/stream (slave -> master):
//     data_out    offset-binary sample, midscale when idle
//     data_valid  high while data_out carries generated samples
//     sync        one-cycle pulse on the first sample of each period
//     cfg_pending a captured configuration waits for the next wrap
// ---------------------------------------------------------------------------
interface dds_wavegen_if #(
    parameter int ACC_W  = 24,
    parameter int LUT_AW = 8,
    parameter int DATA_W = 10
);
    logic              en;
    logic              cfg_load;
    logic [1:0]        wave_sel;
    logic [ACC_W-1:0]  ftw;
    logic [LUT_AW-1:0] phase_ofs;
    logic [8:0]        amp;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              sync;
    logic              cfg_pending;

    modport master (
        output en, cfg_load, wave_sel, ftw, phase_ofs, amp,
        input  data_out, data_valid, sync, cfg_pending
    );

    modport slave (
        input  en, cfg_load, wave_sel, ftw, phase_ofs, amp,
        output data_out, data_valid, sync, cfg_pending
    );
endinterface

// File: rtl/dds_wavegen.sv
// ---------------------------------------------------------------------------
// dds_wavegen
//   Direct digital synthesis waveform generator: phase accumulator, phase to
//   amplitude conversion (sine table, square, triangle, sawtooth) and signed
//   gain around midscale, in a three-stage pipeline.  A new configuration
//   loaded while running is held in a shadow copy and takes effect at the
//   next phase wrap so a period never mixes two configurations.
//
//   Ports:
//     clk   single clock, rising edge
//     rst   synchronous, active-high reset
//     bus   dds_wavegen_if.slave (control inputs, sample stream outputs)
// ---------------------------------------------------------------------------
module dds_wavegen #(
    parameter int ACC_W  = 24,
    parameter int LUT_AW = 8,
    parameter int DATA_W = 10
) (
    input  logic          clk,
    input  logic          rst,
    dds_wavegen_if.slave  bus
);

    localparam int                SH        = DATA_W - LUT_AW;
    localparam int                PW        = DATA_W + 11;
    localparam logic [DATA_W-1:0] MID       = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [8:0]        AMP_UNITY = 9'd256;
    localparam real               PI        = 3.14159265358979323846;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPING} state_t;
    typedef enum logic [1:0] {W_SINE, W_SQUARE, W_TRI, W_SAW} wave_t;

    typedef struct packed {
        wave_t             wave;
        logic [ACC_W-1:0]  ftw;
        logic [LUT_AW-1:0] ofs;
        logic [8:0]        amp;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{wave: W_SINE, ftw: '0, ofs: '0, amp: AMP_UNITY};

    // ------------------------------------------------------------------
    // Full-period sine table, computed at elaboration.
    // ------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] sine_point(input int idx);
        real ang;
        real s;
        int  r;
        ang = 2.0 * PI * real'(idx) / real'(1 << LUT_AW);
        s   = real'((1 << (DATA_W - 1)) - 1) * $sin(ang);
        if (s >= 0.0) r = $rtoi(s + 0.5);
        else          r = -$rtoi(-s + 0.5);
        return DATA_W'((1 << (DATA_W - 1)) + r);
    endfunction

    // NOTE: the table is a set of constant nets, not storage, so there is
    // nothing to reset; only the pipeline registers around it are cleared.
    logic [DATA_W-1:0] sine_rom [1 << LUT_AW];
    for (genvar gi = 0; gi < (1 << LUT_AW); gi++) begin : g_sine
        assign sine_rom[gi] = sine_point(gi);
    end

    // ------------------------------------------------------------------
    // Control: FSM, accumulator, active/shadow configuration
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    cfg_t             act_q, act_d;
    cfg_t             shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             start_q, start_d;   // current sample opens a period

    cfg_t         cfg_in;
    logic [ACC_W:0] sum;
    logic         running;
    logic         wrap;

    always_comb begin
        cfg_in.wave = wave_t'(bus.wave_sel);
        cfg_in.ftw  = bus.ftw;
        cfg_in.ofs  = bus.phase_ofs;
        cfg_in.amp  = (bus.amp > AMP_UNITY) ? AMP_UNITY : bus.amp;
    end

    assign sum     = {1'b0, acc_q} + {1'b0, act_q.ftw};
    assign running = (state_q != S_IDLE);
    assign wrap    = running && sum[ACC_W];

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned (which would infer a latch).
        state_d = state_q;
        acc_d   = acc_q;
        act_d   = act_q;
        shd_d   = shd_q;
        pend_d  = pend_q;
        start_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.en) begin
                    state_d = S_RUN;
                    acc_d   = '0;
                    start_d = 1'b1;
                end
            end
            S_RUN: begin
                acc_d   = sum[ACC_W-1:0];
                start_d = wrap;
                if (!bus.en) state_d = S_STOPPING;
            end
            S_STOPPING: begin
                acc_d = sum[ACC_W-1:0];
                if (bus.en) begin
                    state_d = S_RUN;
                    start_d = wrap;
                end else if (wrap || act_q.ftw == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Configuration changes only at period boundaries while running:
        // a wrap, or the stop that returns to idle. A load on that very
        // cycle wins over the older shadow copy.
        if (state_q == S_IDLE) begin
            if (bus.cfg_load) act_d = cfg_in;
        end else if (wrap || state_d == S_IDLE) begin
            if (bus.cfg_load)  act_d = cfg_in;
            else if (pend_q)   act_d = shd_q;
            pend_d = 1'b0;
        end else if (bus.cfg_load) begin
            shd_d  = cfg_in;
            pend_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath pipeline. Wave and gain travel with each address so every
    // sample is shaped by the configuration of its own period.
    // ------------------------------------------------------------------
    logic [LUT_AW-1:0] p1_q, p1_d;
    wave_t             wave1_q, wave1_d;
    logic [8:0]        amp1_q, amp1_d, amp2_q, amp2_d;
    logic              vld1_q, vld1_d, vld2_q, vld2_d, vld3_q, vld3_d;
    logic              sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic [DATA_W-1:0] raw2_q, raw2_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;

    logic [LUT_AW-1:0] tri_fold, tri_t;
    logic signed [DATA_W:0] diff;
    logic signed [PW-1:0]   prod;

    // Stage 1: table address.
    always_comb begin
        p1_d    = acc_q[ACC_W-1 -: LUT_AW] + act_q.ofs;
        wave1_d = act_q.wave;
        amp1_d  = act_q.amp;
        vld1_d  = running;
        sync1_d = running && start_q;
    end

    // Stage 2: raw waveform. The triangle doubles the address and folds the
    // second half back down.
    assign tri_fold = {p1_q[LUT_AW-2:0], 1'b0};
    assign tri_t    = p1_q[LUT_AW-1] ? ~tri_fold : tri_fold;

    always_comb begin
        raw2_d = '0;
        unique case (wave1_q)
            W_SINE:   raw2_d = sine_rom[p1_q];
            W_SQUARE: raw2_d = p1_q[LUT_AW-1] ? '0 : '1;
            W_TRI:    raw2_d = DATA_W'(tri_t) << SH;
            W_SAW:    raw2_d = DATA_W'(p1_q) << SH;
            default:  raw2_d = '0;
        endcase
        amp2_d  = amp1_q;
        vld2_d  = vld1_q;
        sync2_d = sync1_q;
    end

    // Stage 3: gain about midscale. The arithmetic shift floors toward
    // minus infinity; gain <= unity keeps the result inside the code range.
    assign diff = $signed({1'b0, raw2_q}) - $signed({1'b0, MID});
    assign prod = PW'(diff) * PW'($signed({1'b0, amp2_q}));

    always_comb begin
        data_out_d = vld2_q ? (MID + DATA_W'(prod >>> 8)) : MID;
        vld3_d     = vld2_q;
        sync3_d    = sync2_q;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its peers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            act_q      <= CFG_RESET;
            shd_q      <= CFG_RESET;
            pend_q     <= 1'b0;
            start_q    <= 1'b0;
            p1_q       <= '0;
            wave1_q    <= W_SINE;
            amp1_q     <= AMP_UNITY;
            vld1_q     <= 1'b0;
            sync1_q    <= 1'b0;
            raw2_q     <= MID;
            amp2_q     <= AMP_UNITY;
            vld2_q     <= 1'b0;
            sync2_q    <= 1'b0;
            data_out_q <= MID;
            vld3_q     <= 1'b0;
            sync3_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            act_q      <= act_d;
            shd_q      <= shd_d;
            pend_q     <= pend_d;
            start_q    <= start_d;
            p1_q       <= p1_d;
            wave1_q    <= wave1_d;
            amp1_q     <= amp1_d;
            vld1_q     <= vld1_d;
            sync1_q    <= sync1_d;
            raw2_q     <= raw2_d;
            amp2_q     <= amp2_d;
            vld2_q     <= vld2_d;
            sync2_q    <= sync2_d;
            data_out_q <= data_out_d;
            vld3_q     <= vld3_d;
            sync3_q    <= sync3_d;
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.data_valid  = vld3_q;
    assign bus.sync        = sync3_q;
    assign bus.cfg_pending = pend_q;

endmodule

// File: doc/dds_wavegen.md
DDS_WAVEGEN -- requirements
Module: dds_wavegen

Interface
REQ-001 Parameter ACC_W, default 24, phase accumulator width (16..32).
REQ-002 Parameter LUT_AW, default 8, phase-to-amplitude address width (4..12).
REQ-003 Parameter DATA_W, default 10, output sample width; DATA_W >= LUT_AW.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 en  in  1  1 = generate, 0 = request stop at next phase wrap.
REQ-007 cfg_load  in  1  one-cycle strobe capturing wave_sel, ftw, phase_ofs, amp.
REQ-008 wave_sel  in  2  0 sine, 1 square, 2 triangle, 3 sawtooth.
REQ-009 ftw  in  ACC_W  frequency tuning word (accumulator step).
REQ-010 phase_ofs  in  LUT_AW  phase offset added to table address.
REQ-011 amp  in  9  amplitude gain, 256 = unity; values >256 clamp to 256.
REQ-012 data_out  out  DATA_W  offset-binary sample, midscale MID = 2^(DATA_W-1).
REQ-013 data_valid  out  1  high while data_out carries generated samples.
REQ-014 sync  out  1  one-cycle pulse on the sample produced at phase 0 of each period.
REQ-015 cfg_pending  out  1  captured configuration awaiting the next wrap.

Function
REQ-016 FSM states IDLE, RUN, STOPPING; IDLE->RUN when en=1; RUN->STOPPING when en=0; STOPPING->RUN when en=1 (accumulator not cleared); STOPPING->IDLE on wrap cycle, or immediately when active ftw=0.
REQ-017 In RUN/STOPPING, acc <= acc + ftw modulo 2^ACC_W; wrap = carry out of that addition.
REQ-018 On IDLE->RUN, acc cleared to 0 so the first sample is phase 0 (+phase_ofs) and sync fires with it.
REQ-019 Table address p = (acc[ACC_W-1 -: LUT_AW] + phase_ofs) mod 2^LUT_AW.
REQ-020 Sine raw = MID + round((MID-1)*sin(2*pi*p/2^LUT_AW)); quarter-wave or full table allowed, values bit-exact.
REQ-021 Square raw = 2^DATA_W-1 when p MSB=0, else 0.
REQ-022 Sawtooth raw = p << (DATA_W-LUT_AW).
REQ-023 Triangle raw = t << (DATA_W-LUT_AW), t = (p<<1) mod 2^LUT_AW if p MSB=0, else bitwise-inverse of that.
REQ-024 Output = MID + floor((raw-MID)*amp_c/256), signed arithmetic, amp_c clamped amp; never exceeds 0..2^DATA_W-1.
REQ-025 Pipeline latency fixed at 3 cycles from accumulator register to data_out/data_valid/sync; all three delayed equally.
REQ-026 data_valid rises 3 cycles after IDLE->RUN, falls 3 cycles after STOPPING->IDLE; while low, data_out = MID.
REQ-027 cfg_load in IDLE: values applied to active config next cycle; cfg_pending stays 0.
REQ-028 cfg_load in RUN/STOPPING: values captured into shadow, cfg_pending=1; shadow applied on the cycle after wrap, cfg_pending cleared.
REQ-029 Multiple cfg_load before a wrap: last one wins.
REQ-030 cfg_load coinciding with a wrap cycle: those values applied at that wrap; cfg_pending ends 0.
REQ-031 Pending config with active ftw=0 applies when stop to IDLE occurs or on next cfg_load in IDLE.
REQ-032 Samples within one period never mix old and new wave_sel/ftw/phase_ofs/amp.

Reset
REQ-033 rst forces state IDLE, acc=0, active and shadow config=0 (amp=256), pipeline flushed.
REQ-034 During and after reset: data_out=MID, data_valid=0, sync=0, cfg_pending=0.
REQ-035 rst mid-RUN takes effect next edge; outputs show reset values on the following cycle with no pipelined samples emerging.

Verification
REQ-036 Defaults; cfg_load in IDLE saw, ftw=0x010000, phase_ofs=0, amp=256; en=1 -> data_valid after 3 cycles, data_out 0,4,8,...,1020, sync every 256 samples.
REQ-037 Square, ftw=0x008000, amp=128 -> 512 samples per period: 256 samples 767, then 256 samples 256.
REQ-038 Sine, ftw=0x010000, phase_ofs=64 -> first sample 1023 (cosine start), sample 128 = 1.
REQ-039 In RUN, cfg_load ftw=0x020000 mid-period -> cfg_pending=1 until wrap; period length changes from 256 to 128 exactly at the sync sample.
REQ-040 en=0 at sample 10 of a saw period -> samples continue to 1020, data_valid falls after wrap, data_out=MID; en=0 with ftw=0 -> stop immediately.
REQ-041 rst asserted mid-RUN with pending config -> next cycle data_out=512, data_valid=0, cfg_pending=0; restart uses amp=256, ftw=0.
